serial_alu_ctrl: RTL
====================

SERIAL_ALU_CTRL -- requirements
Module: serial_alu_ctrl

Interface
REQ-001 SHALL have parameter: WIDTH, default 8, operand/result width in bits (legal range 2..32).
REQ-002 SHALL have port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port: rst_n  input  1  reset, synchronous, active-low.
REQ-004 SHALL have port: start  input  1  request a new operation; sampled only in IDLE.
REQ-005 SHALL have port: op  input  3  0 AND, 1 OR, 2 ADD, 3 SUB, 4 NOR, 5 SLT, 6-7 invalid.
REQ-006 SHALL have ports: a, b  input  WIDTH each  operands; two's complement for ADD/SUB/SLT.
REQ-007 SHALL have port: result  output  WIDTH  registered result; held until the next accepted start.
REQ-008 SHALL have port: carry_out  output  1  final carry of ADD/SUB; 0 for all other ops.
REQ-009 SHALL have port: overflow  output  1  signed overflow of ADD/SUB/SLT; 0 for all other ops.
REQ-010 SHALL have port: zero  output  1  high when result == 0.
REQ-011 SHALL have port: busy  output  1  high in RUN and DONE.
REQ-012 SHALL have port: done  output  1  single-cycle pulse when result and flags are valid.

Function
REQ-013 SHALL implement FSM states IDLE, RUN, DONE.
- IDLE->RUN on start=1.
- RUN->DONE after WIDTH bit cycles.
- DONE->IDLE unconditionally.
REQ-014 At the accepting edge, SHALL latch a, b and op, and clear bit index, result shift register and all flags.
REQ-015 SHALL evaluate one bit per cycle in RUN, LSB first, using an internal 1-bit slice.
- Slice inputs: A, B, Ainv, Binv, Cin, 2-bit operation; operation 0 AND, 1 OR, 2 SUM.
- Slice outputs: selected bit, carry out.
REQ-016 SHALL drive slice controls {Ainv, Binv, operation} per op:
- AND {0,0,0}; OR {0,0,1}; ADD {0,0,2}; SUB {0,1,2}; NOR {1,1,0}; SLT {0,1,2}.
REQ-017 SHALL hold the slice carry in a flip-flop.
- Initialise to 1 for SUB/SLT and to 0 otherwise at the accepting edge.
- Update from slice carry out on every RUN cycle.
REQ-018 SHALL shift each slice output into result MSB while shifting right, so result is aligned after WIDTH cycles.
REQ-019 For SLT, SHALL set result = {WIDTH-1 zeros, (diff MSB XOR overflow)}.
REQ-020 SHALL compute overflow = carry into MSB XOR carry out of MSB.
REQ-021 For op 6/7, SHALL still take WIDTH cycles and report result=0, carry_out=0, overflow=0, zero=1.
REQ-022 SHALL present result, carry_out, overflow and zero updated at the same edge that raises done.
REQ-023 Latency: start sampled at edge E; done high for exactly the cycle between edges E+WIDTH and E+WIDTH+1.
REQ-024 SHALL ignore start in RUN and DONE, with no queueing.
- start held high continuously therefore yields back-to-back operations with one IDLE cycle between them.
REQ-025 SHALL not react to operand changes after the accepting edge.

Reset
REQ-026 rst_n=0 at a rising edge SHALL force IDLE and clear all of the following to 0: result, carry_out, overflow, zero, busy, done, carry FF, bit index.
REQ-027 Reset asserted in RUN or DONE SHALL abort the operation with no done pulse; the first start after release SHALL behave as from power-up.

Verification (WIDTH=8)
REQ-028 ADD a=0x7F, b=0x01 -> result=0x80, overflow=1, carry_out=0, zero=0; done exactly 8 edges after the accepting edge.
REQ-029 SUB a=0x05, b=0x05 -> result=0x00, zero=1, carry_out=1, overflow=0.
REQ-030 SLT a=0x80, b=0x01 -> result=0x01; SLT a=0x01, b=0x80 -> result=0x00, overflow=1.
REQ-031 NOR a=0xF0, b=0x0F -> result=0x00, zero=1; OR with the same operands -> 0xFF, carry_out=0.
REQ-032 Start pulse with a different op/operands while busy=1 -> ignored; the first result is unchanged; exactly one done.
REQ-033 rst_n=0 for one edge at bit 4 of an ADD -> all outputs 0 and no done; the next ADD 0x03+0x04 -> 0x07.

Source files
------------

// File: rtl/serial_alu_ctrl.sv
// serial_alu_ctrl: bit-serial ALU sequencer built around a single 1-bit ALU slice.
// One operand bit is evaluated per clock, LSB first; an operation takes WIDTH
// RUN cycles and ends with a one-cycle done pulse.
//
// Ports
//   clk        single clock, rising edge
//   rst_n      synchronous active-low reset
//   start      request a new operation (sampled only in IDLE)
//   op[2:0]    0 AND, 1 OR, 2 ADD, 3 SUB, 4 NOR, 5 SLT, 6-7 invalid
//   a, b       operands, latched on the accepting edge
//   result     registered result, held until the next accepted start
//   carry_out  final carry of ADD/SUB
//   overflow   signed overflow of ADD/SUB/SLT
//   zero       result == 0
//   busy       high in RUN and DONE
//   done       one-cycle pulse when result and flags are valid
//
// state  | meaning
// IDLE   | waiting for start; outputs hold the last result
// RUN    | one slice evaluation per cycle, WIDTH cycles
// DONE   | result/flags valid, done asserted for this single cycle

module alu_slice (
   input  logic       i_a,
   input  logic       i_b,
   input  logic       i_ainv,
   input  logic       i_binv,
   input  logic       i_cin,
   input  logic [1:0] i_sel,
   output logic       o_bit,
   output logic       o_cout
);
   logic w_a;
   logic w_b;

   assign w_a    = i_ainv ? ~i_a : i_a;
   assign w_b    = i_binv ? ~i_b : i_b;
   assign o_cout = (w_a & w_b) | (i_cin & (w_a ^ w_b));

   always_comb begin
      o_bit = 1'b0;
      case (i_sel)
         2'd0:    o_bit = w_a & w_b;
         2'd1:    o_bit = w_a | w_b;
         2'd2:    o_bit = w_a ^ w_b ^ i_cin;
         default: o_bit = 1'b0;
      endcase
   end
endmodule

module serial_alu_ctrl #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [2:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic [WIDTH-1:0] result,
   output logic             carry_out,
   output logic             overflow,
   output logic             zero,
   output logic             busy,
   output logic             done
);
   localparam int IW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
   localparam logic [IW-1:0] IDX_LAST = IW'(WIDTH - 1);

   localparam logic [2:0] OP_AND = 3'd0;
   localparam logic [2:0] OP_OR  = 3'd1;
   localparam logic [2:0] OP_ADD = 3'd2;
   localparam logic [2:0] OP_SUB = 3'd3;
   localparam logic [2:0] OP_NOR = 3'd4;
   localparam logic [2:0] OP_SLT = 3'd5;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t           r_state;
   state_t           w_next;
   logic [WIDTH-1:0] r_a;
   logic [WIDTH-1:0] r_b;
   logic [2:0]       r_op;
   logic [IW-1:0]    r_idx;
   logic             r_carry;
   logic [WIDTH-1:0] r_shift;
   logic [WIDTH-1:0] r_result;
   logic             r_carry_out;
   logic             r_overflow;
   logic             r_zero;

   logic             w_accept;
   logic             w_last;
   logic             w_ainv;
   logic             w_binv;
   logic [1:0]       w_sel;
   logic             w_bit;
   logic             w_cout;
   logic             w_ovf;
   logic [WIDTH-1:0] w_shift_next;
   logic [WIDTH-1:0] w_res_final;
   logic             w_c_final;
   logic             w_v_final;

   assign w_accept = (r_state == S_IDLE) && start;
   assign w_last   = (r_state == S_RUN) && (r_idx == IDX_LAST);

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:  if (start) w_next = S_RUN;
         S_RUN:   if (r_idx == IDX_LAST) w_next = S_DONE;
         S_DONE:  w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   // Slice controls {Ainv, Binv, operation}; SLT is evaluated as a subtraction.
   always_comb begin
      w_ainv = 1'b0;
      w_binv = 1'b0;
      w_sel  = 2'd0;
      case (r_op)
         OP_AND: w_sel = 2'd0;
         OP_OR:  w_sel = 2'd1;
         OP_ADD: w_sel = 2'd2;
         OP_SUB: begin w_binv = 1'b1; w_sel = 2'd2; end
         OP_NOR: begin w_ainv = 1'b1; w_binv = 1'b1; w_sel = 2'd0; end
         OP_SLT: begin w_binv = 1'b1; w_sel = 2'd2; end
         default: w_sel = 2'd0;
      endcase
   end

   alu_slice u_slice (
      .i_a    (r_a[0]),
      .i_b    (r_b[0]),
      .i_ainv (w_ainv),
      .i_binv (w_binv),
      .i_cin  (r_carry),
      .i_sel  (w_sel),
      .o_bit  (w_bit),
      .o_cout (w_cout)
   );

   // On the last RUN cycle r_carry is the carry into the MSB.
   assign w_ovf        = r_carry ^ w_cout;
   assign w_shift_next = {w_bit, r_shift[WIDTH-1:1]};

   always_comb begin
      w_res_final = w_shift_next;
      w_c_final   = 1'b0;
      w_v_final   = 1'b0;
      case (r_op)
         OP_AND, OP_OR, OP_NOR: w_res_final = w_shift_next;
         OP_ADD, OP_SUB: begin
            w_c_final = w_cout;
            w_v_final = w_ovf;
         end
         OP_SLT: begin
            w_res_final = {{(WIDTH-1){1'b0}}, w_bit ^ w_ovf};
            w_v_final   = w_ovf;
         end
         default: w_res_final = '0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state     <= S_IDLE;
         r_a         <= '0;
         r_b         <= '0;
         r_op        <= 3'd0;
         r_idx       <= '0;
         r_carry     <= 1'b0;
         r_shift     <= '0;
         r_result    <= '0;
         r_carry_out <= 1'b0;
         r_overflow  <= 1'b0;
         r_zero      <= 1'b0;
      end else begin
         r_state <= w_next;
         if (w_accept) begin
            r_a         <= a;
            r_b         <= b;
            r_op        <= op;
            r_idx       <= '0;
            r_carry     <= (op == OP_SUB) || (op == OP_SLT);
            r_shift     <= '0;
            r_result    <= '0;
            r_carry_out <= 1'b0;
            r_overflow  <= 1'b0;
            r_zero      <= 1'b0;
         end else if (r_state == S_RUN) begin
            r_a     <= r_a >> 1;
            r_b     <= r_b >> 1;
            r_carry <= w_cout;
            r_idx   <= r_idx + IW'(1);
            r_shift <= w_shift_next;
            if (w_last) begin
               r_result    <= w_res_final;
               r_carry_out <= w_c_final;
               r_overflow  <= w_v_final;
               r_zero      <= (w_res_final == '0);
            end
         end
      end
   end

   assign result    = r_result;
   assign carry_out = r_carry_out;
   assign overflow  = r_overflow;
   assign zero      = r_zero;
   assign busy      = (r_state != S_IDLE);
   assign done      = (r_state == S_DONE);
endmodule
